// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM configuration register arbiter.
// Register map, FSM encoding and the address range helper live here.
package pwm_cfg_pkg;

  localparam int CFG_ADDR_W = 7;
  localparam int CFG_DATA_W = 8;
  localparam int NUM_REGS   = 5;

  localparam int ADDR_EN_OUT_LO = 'h00;
  localparam int ADDR_EN_OUT_HI = 'h01;
  localparam int ADDR_EN_PWM_LO = 'h02;
  localparam int ADDR_EN_PWM_HI = 'h03;
  localparam int ADDR_DUTY      = 'h04;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  function automatic logic addr_in_range(input int addr, input int num_regs);
    return (addr < num_regs);
  endfunction

endpackage

// File: rtl/pwm_cfg_regfile.sv
// Five 8-bit PWM configuration registers with address range checking.
// Writes land at the end of the cycle in which wr_en is high and the address is mapped.
module pwm_cfg_regfile
  import pwm_cfg_pkg::*;
#(
  parameter int ADDR_W   = CFG_ADDR_W,
  parameter int DATA_W   = CFG_DATA_W,
  parameter int NUM_REGS = pwm_cfg_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_ok,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle
);

  logic wr_ok;

  // chk_addr lets the arbiter classify a request before it is committed.
  always_comb begin
    chk_ok = addr_in_range(int'(chk_addr), NUM_REGS);
    wr_ok  = addr_in_range(int'(wr_addr), NUM_REGS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (wr_en && wr_ok) begin
      case (int'(wr_addr))
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= wr_data;
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= wr_data;
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= wr_data;
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= wr_data;
        ADDR_DUTY:      pwm_duty_cycle  <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Two-requester write arbiter for the PWM configuration registers.
// Handshake: a requester holds valid/addr/data stable until it sees a one-cycle ready (err qualifies it).
module pwm_cfg_arbiter
  import pwm_cfg_pkg::*;
#(
  parameter int ADDR_W   = CFG_ADDR_W,
  parameter int DATA_W   = CFG_DATA_W,
  parameter int NUM_REGS = pwm_cfg_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prio_mode,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              req1_err,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              cfg_wr_strobe,
  output logic [ADDR_W-1:0] cfg_wr_addr,
  output state_t            state_dbg
);

  state_t            state;
  logic              rr_ptr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic              any_valid;
  logic              win1;
  logic [ADDR_W-1:0] cand_addr;
  logic [DATA_W-1:0] cand_data;
  logic              cand_ok;

  // Winner selection; rr_ptr = 1 means requester 1 is favoured on contention.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    win1      = 1'b0;
    if (req0_valid && req1_valid) begin
      win1 = prio_mode ? 1'b0 : rr_ptr;
    end else if (req1_valid) begin
      win1 = 1'b1;
    end
    cand_addr = win1 ? req1_addr : req0_addr;
    cand_data = win1 ? req1_data : req0_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      lat_addr      <= '0;
      lat_data      <= '0;
      req0_ready    <= 1'b0;
      req1_ready    <= 1'b0;
      req0_err      <= 1'b0;
      req1_err      <= 1'b0;
      cfg_wr_strobe <= 1'b0;
      cfg_wr_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state         <= COMMIT;
            lat_addr      <= cand_addr;
            lat_data      <= cand_data;
            rr_ptr        <= ~win1;
            req0_ready    <= ~win1;
            req1_ready    <= win1;
            req0_err      <= ~win1 & ~cand_ok;
            req1_err      <= win1 & ~cand_ok;
            cfg_wr_strobe <= cand_ok;
            if (cand_ok) begin
              cfg_wr_addr <= cand_addr;
            end
          end
        end
        COMMIT: begin
          // The register file consumes the strobe during this cycle.
          state         <= IDLE;
          req0_ready    <= 1'b0;
          req1_ready    <= 1'b0;
          req0_err      <= 1'b0;
          req1_err      <= 1'b0;
          cfg_wr_strobe <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

  pwm_cfg_regfile #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (cfg_wr_strobe),
    .wr_addr         (lat_addr),
    .wr_data         (lat_data),
    .chk_addr        (cand_addr),
    .chk_ok          (cand_ok),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

endmodule
